msdap_serial_tx: RTL and testbench

Synthesizable, parametrised multi-channel serial word transmitter that feeds the MSDAP core. It replaces the fixed bench-only stimulus path with a reusable source.
- Takes parallel words per channel over a valid/ready handshake.
- Serializes each word MSB-first at a programmable bit rate derived from sClk.
- Marks the first bit of every word with frame.
- Honours the core's inReady.
- Tracks the Rj / coefficient / data section sequence and signals completion.

---
 rtl/msdap_serial_tx.sv | 114 +++++++++++
 tb/tb_msdap_serial_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/msdap_serial_tx.sv
// msdap_serial_tx: multi-channel MSB-first serial word source for the MSDAP core.
// Tracks the Rj / coefficient / data sections and stops after a bounded data run.
module msdap_serial_tx #(
    parameter int NCH         = 2,
    parameter int WIDTH       = 16,
    parameter int DIV         = 34,
    parameter int RJ_WORDS    = 16,
    parameter int COEFF_WORDS = 512,
    parameter int CNT_W       = 32
) (
    input  logic                   sClk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       data_count,
    input  logic [NCH*WIDTH-1:0]   word_data,
    input  logic                   word_valid,
    output logic                   word_ready,
    input  logic                   in_ready,
    output logic                   bit_tick,
    output logic                   frame,
    output logic [NCH-1:0]         ser_data,
    output logic [1:0]             section,
    output logic [CNT_W-1:0]       words_sent,
    output logic                   busy,
    output logic                   done
);
    localparam int BW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam int DW = $clog2(DIV);
    localparam logic [CNT_W-1:0] RJ_N = CNT_W'(RJ_WORDS);
    localparam logic [CNT_W-1:0] RC_N = CNT_W'(RJ_WORDS + COEFF_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SHIFT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    div_q, div_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] sr_q [NCH];
    logic [WIDTH-1:0] sr_d [NCH];
    logic             frame_q, frame_d;
    logic [1:0]       sec_q, sec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, limit_q, limit_d, inc;
    logic             last, fin;

    assign busy       = state_q == S_WAIT || state_q == S_SHIFT;
    assign done       = state_q == S_DONE;
    assign bit_tick   = busy && div_q == DW'(DIV - 1);
    assign inc        = cnt_q + 1'b1;
    assign last       = state_q == S_SHIFT && bit_tick && bit_q == '0;
    assign fin        = last && limit_q != '0 && inc == RC_N + limit_q;
    assign word_ready = bit_tick && in_ready && word_valid && (state_q == S_WAIT || (last && !fin));
    assign section    = done ? 2'd3 : sec_q;
    assign frame      = frame_q;
    assign words_sent = cnt_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ser
        assign ser_data[c] = state_q == S_SHIFT && sr_q[c][WIDTH-1];
    end

    always_comb begin
        state_d = state_q;
        div_d   = busy ? (bit_tick ? '0 : div_q + 1'b1) : div_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        frame_d = bit_tick ? 1'b0 : frame_q;
        sec_d   = sec_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        if ((state_q == S_IDLE || done) && start) begin
            state_d = S_WAIT;
            div_d   = '0;
            cnt_d   = '0;
            sec_d   = 2'd0;
            limit_d = data_count;
        end
        if (state_q == S_SHIFT && bit_tick && !last) begin
            for (int c = 0; c < NCH; c++) sr_d[c] = sr_q[c] << 1;
            bit_d = bit_q - 1'b1;
        end
        if (last) begin
            cnt_d   = inc;
            // once past the coefficients stay in DATA, even when the counter wraps
            sec_d   = (sec_q == 2'd2 || inc >= RC_N) ? 2'd2 : (inc >= RJ_N ? 2'd1 : 2'd0);
            state_d = fin ? S_DONE : S_WAIT;
        end
        if (word_ready) begin
            for (int c = 0; c < NCH; c++) sr_d[c] = word_data[c*WIDTH +: WIDTH];
            frame_d = 1'b1;
            bit_d   = BW'(WIDTH - 1);
            state_d = S_SHIFT;
        end
    end

    always_ff @(posedge sClk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            for (int c = 0; c < NCH; c++) sr_q[c] <= '0;
            frame_q <= 1'b0;
            sec_q   <= 2'd0;
            cnt_q   <= '0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            frame_q <= frame_d;
            sec_q   <= sec_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
        end
    end
endmodule

// File: tb/tb_msdap_serial_tx.sv
// tb_msdap_serial_tx: table rows plus hand sequences, checked every cycle against a
// timing model that predicts outputs from start and acceptance times.
module tb_msdap_serial_tx;
    localparam int NCH = 2, WIDTH = 4, DIV = 3, RJ = 2, CO = 3, CNT_W = 4, MOD = 16;

    logic             sClk, reset_n, start, word_valid, in_ready;
    logic [CNT_W-1:0] data_count, words_sent;
    logic [7:0]       word_data;
    logic             word_ready, bit_tick, frame, busy, done;
    logic [1:0]       ser_data, section;

    msdap_serial_tx #(.NCH(NCH), .WIDTH(WIDTH), .DIV(DIV), .RJ_WORDS(RJ),
                      .COEFF_WORDS(CO), .CNT_W(CNT_W)) dut (
        .sClk(sClk), .reset_n(reset_n), .start(start), .data_count(data_count),
        .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
        .in_ready(in_ready), .bit_tick(bit_tick), .frame(frame), .ser_data(ser_data),
        .section(section), .words_sent(words_sent), .busy(busy), .done(done)
    );

    int n_chk = 0, n_fail = 0, cyc = 0;
    int v_pct = 0, r_pct = 0, adv = 0, adv_seen = 0;
    bit fx = 1'b1, v_hold = 1'b0, r_hold = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    initial begin
        sClk = 1'b0;
        forever #5 sClk = ~sClk;
    end

    // stimulus driver: a fresh word after each acceptance, random handshake levels
    always @(posedge sClk) begin
        #2;
        if (adv != adv_seen) begin
            adv_seen  = adv;
            word_data = fx ? 8'h5A : 8'($urandom);
        end
        word_valid = !v_hold && ($urandom_range(99) < v_pct);
        in_ready   = !r_hold && ($urandom_range(99) < r_pct);
    end

    // reference model: time since start fixes tick phase, time since acceptance fixes bit
    bit       m_busy = 0, m_done = 0, tick, in_word, ending, fin, e_rdy, idle;
    int       w0 = 0, acc = -1000, phase, m_cnt = 0, m_tot = 0, m_limit = 0, m_sec = 0;
    logic [7:0] cur_w = '0;
    logic [1:0] e_ser;

    always @(negedge sClk) begin
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_cnt = 0; m_tot = 0; m_sec = 0; acc = -1000;
        end
        tick    = m_busy && ((cyc - w0) % DIV == DIV - 1);
        phase   = cyc - acc;
        in_word = m_busy && phase >= 1 && phase <= WIDTH * DIV;
        ending  = tick && in_word && phase == WIDTH * DIV;
        fin     = ending && m_limit != 0 && (m_cnt + 1) % MOD == (RJ + CO + m_limit) % MOD;
        e_rdy   = tick && (!in_word || ending) && !fin && word_valid && in_ready;
        e_ser   = '0;
        if (in_word)
            for (int c = 0; c < NCH; c++) e_ser[c] = cur_w[c*WIDTH + WIDTH - 1 - (phase - 1) / DIV];
        chk("word_ready", word_ready, e_rdy);
        chk("bit_tick", bit_tick, tick);
        chk("frame", frame, in_word && phase <= DIV);
        chk("ser_data", ser_data, e_ser);
        chk("section", section, m_done ? 3 : m_sec);
        chk("words_sent", words_sent, m_cnt);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        if (reset_n) begin
            idle = !m_busy;
            if (ending) begin
                m_cnt = (m_cnt + 1) % MOD;
                m_tot++;
                m_sec = m_tot >= RJ + CO ? 2 : (m_tot >= RJ ? 1 : 0);
            end
            if (fin) begin m_busy = 0; m_done = 1; end
            if (e_rdy) begin acc = cyc; cur_w = word_data; adv++; end
            if (idle && start) begin
                m_busy = 1; m_done = 0; w0 = cyc + 1; m_cnt = 0; m_tot = 0; m_sec = 0;
                m_limit = int'(data_count); acc = -1000;
            end
        end
        cyc++;
    end

    task automatic pulse_start(input int dc);
        @(posedge sClk); #1;
        data_count = CNT_W'(dc);
        start = 1'b1;
        @(posedge sClk); #1;
        start = 1'b0;
    endtask

    task automatic wait_words(input int w, input int budget, input string nm);
        int k = 0;
        while (int'(words_sent) != w && k < budget) begin
            @(negedge sClk);
            k++;
        end
        chk(nm, words_sent, w);
    endtask

    task automatic wait_done(input int budget, output int k);
        k = 0;
        while (!done && k < budget) begin
            @(negedge sClk);
            k++;
        end
    endtask

    typedef struct {
        int dc; int vp; int rp; bit fx; int budget; bit e_done; int e_words; int e_first; int e_cyc;
    } row_t;

    row_t rows[4];
    int   k, first, rdy, ticks;

    initial begin
        rows[0] = '{2, 100, 100, 1'b1, 200, 1'b1, 7, 4, 88};
        rows[1] = '{3, 70, 70, 1'b0, 1500, 1'b1, 8, 0, 0};
        rows[2] = '{1, 100, 100, 1'b0, 200, 1'b1, 6, 4, 76};
        rows[3] = '{5, 50, 80, 1'b0, 2000, 1'b1, 10, 0, 0};
        reset_n = 1'b0; start = 1'b0; data_count = '0; word_data = 8'h5A;
        word_valid = 1'b0; in_ready = 1'b0;
        repeat (2) @(posedge sClk);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge sClk);
        for (int r = 0; r < 4; r++) begin
            v_pct = rows[r].vp; r_pct = rows[r].rp; fx = rows[r].fx;
            pulse_start(rows[r].dc);
            k = 0; first = 0;
            while (!done && k < rows[r].budget) begin
                @(negedge sClk);
                k++;
                if (frame && first == 0) first = k;
            end
            chk("row done", done, rows[r].e_done);
            chk("row words", words_sent, rows[r].e_words);
            if (rows[r].e_first != 0) chk("row first frame", first, rows[r].e_first);
            if (rows[r].e_cyc != 0) chk("row cycles to done", k, rows[r].e_cyc);
        end
        // word_valid low across the end of word 3
        v_pct = 100; r_pct = 100; fx = 1'b0;
        pulse_start(6);
        wait_words(2, 100, "valid drop reach word 3");
        repeat (8) @(negedge sClk);
        @(posedge sClk); #1 v_hold = 1'b1;
        rdy = 0;
        repeat (10) begin @(negedge sClk); if (word_ready) rdy++; end
        chk("accept while invalid", rdy, 0);
        chk("words during valid drop", words_sent, 3);
        @(posedge sClk); #1 v_hold = 1'b0;
        wait_done(400, k);
        chk("valid drop done", done, 1);
        chk("valid drop words", words_sent, 11);
        // in_ready low from bit 1 of word 4
        pulse_start(6);
        wait_words(3, 100, "ready drop reach word 4");
        repeat (3) @(negedge sClk);
        @(posedge sClk); #1 r_hold = 1'b1;
        rdy = 0;
        repeat (14) begin @(negedge sClk); if (word_ready) rdy++; end
        chk("accept while not ready", rdy, 0);
        chk("word 4 completed", words_sent, 4);
        @(posedge sClk); #1 r_hold = 1'b0;
        wait_done(400, k);
        chk("ready drop words", words_sent, 11);
        // unbounded run with a start pulse while busy
        pulse_start(0);
        wait_words(15, 400, "unbounded reach 15");
        pulse_start(3);
        wait_words(0, 40, "unbounded wrap to 0");
        chk("unbounded section after wrap", section, 2);
        wait_words(6, 200, "unbounded 22 words");
        chk("unbounded no done", done, 0);
        chk("unbounded section", section, 2);
        // asynchronous reset mid-stream
        @(posedge sClk); #3 reset_n = 1'b0;
        #1;
        chk("reset frame", frame, 0);
        chk("reset ser_data", ser_data, 0);
        chk("reset busy", busy, 0);
        chk("reset section", section, 0);
        chk("reset words_sent", words_sent, 0);
        chk("reset bit_tick", bit_tick, 0);
        @(posedge sClk); #3 reset_n = 1'b1;
        ticks = 0;
        repeat (20) begin @(negedge sClk); if (bit_tick) ticks++; end
        chk("ticks after reset", ticks, 0);
        pulse_start(2);
        wait_done(200, k);
        chk("rerun after reset done", done, 1);
        chk("rerun after reset words", words_sent, 7);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
